// File: rtl/fpu_pkg.sv
// Shared types for the FPU sequencer: unit opcodes, sequencer states and the
// highest legal opcode.
package fpu_pkg;

    // Unit select codes understood by the FPU; anything above FPU_OP_MAX is illegal.
    typedef enum logic [3:0] {
        OP_FADD  = 4'd0,
        OP_FSUB  = 4'd1,
        OP_FMUL  = 4'd2,
        OP_FDIV  = 4'd3,
        OP_FSQRT = 4'd4,
        OP_FTOI  = 4'd5,
        OP_FEQ   = 4'd6,
        OP_FLT   = 4'd7,
        OP_FLE   = 4'd8,
        OP_ITOF  = 4'd9
    } fpu_op_e;

    localparam logic [3:0] FPU_OP_MAX = 4'd9;

    // Sequencer states; at most one operation is in flight.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } fpu_state_e;

    // True when the opcode selects an existing FPU unit.
    function automatic logic op_legal(input logic [3:0] op);
        return (op <= FPU_OP_MAX);
    endfunction

endpackage

// File: rtl/fpu_sequencer.sv
// Single-operation sequencer between a core and a multi-unit FPU. Latches a
// request, pulses fpu_go for one cycle, waits for fpu_valid (or a timeout),
// then holds the response until the core takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready does not depend on req_valid; resp_valid does not depend
// on resp_ready. Once resp_valid is raised, resp_data/resp_tag/resp_err stay
// unchanged until the cycle in which resp_ready is 1.
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rstn,
    // request from the core
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic             req_mode,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    // response to the core
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    // FPU side
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic             fpu_go,
    output logic [3:0]       fpu_control,
    output logic             fpu_mode,
    input  logic [31:0]      fpu_c,
    input  logic             fpu_valid,
    // status
    output logic             busy,
    output fpu_state_e       dbg_state
);

    // Counter is at least 8 bits and wide enough to hold TIMEOUT.
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    fpu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        fpu_a_q, fpu_b_q;
    logic [3:0]         fpu_control_q;
    logic               fpu_mode_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        resp_data_q;
    logic               resp_err_q;

    logic               accept;
    logic               acc_legal;
    logic               fpu_hit;
    logic               timeout_hit;

    assign accept    = req_valid && req_ready;
    assign acc_legal = op_legal(req_op);
    // FPU result is only looked at while an op is outstanding.
    assign fpu_hit   = fpu_valid && ((state_q == ISSUE) || (state_q == WAIT));
    // cnt_q is 0 in the first WAIT cycle, so this lands RESP exactly
    // TIMEOUT cycles after the ISSUE cycle.
    assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 2));

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = acc_legal ? ISSUE : RESP;
            end
            ISSUE: begin
                state_d = fpu_valid ? RESP : WAIT;
            end
            WAIT: begin
                if (fpu_valid || timeout_hit) state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (accept) state_d = acc_legal ? ISSUE : RESP;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req_ready  = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
        resp_valid = (state_q == RESP);
        fpu_go     = (state_q == ISSUE);
        busy       = (state_q != IDLE);
    end

    // Operand/tag capture, result capture and the issue-relative cycle counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fpu_a_q       <= '0;
            fpu_b_q       <= '0;
            fpu_control_q <= '0;
            fpu_mode_q    <= 1'b0;
            tag_q         <= '0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            if (accept) begin
                fpu_a_q       <= req_a;
                fpu_b_q       <= req_b;
                fpu_control_q <= req_op;
                fpu_mode_q    <= req_mode;
                tag_q         <= req_tag;
                if (!acc_legal) begin
                    resp_data_q <= '0;
                    resp_err_q  <= 1'b1;
                end
            end
            // A valid result takes priority over a coincident timeout.
            if (fpu_hit) begin
                resp_data_q <= fpu_c;
                resp_err_q  <= 1'b0;
            end else if (timeout_hit) begin
                resp_data_q <= '0;
                resp_err_q  <= 1'b1;
            end
            if (state_q == ISSUE)     cnt_q <= '0;
            else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign fpu_a       = fpu_a_q;
    assign fpu_b       = fpu_b_q;
    assign fpu_control = fpu_control_q;
    assign fpu_mode    = fpu_mode_q;
    assign resp_data   = resp_data_q;
    assign resp_tag    = tag_q;
    assign resp_err    = resp_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer with a behavioural FPU of programmable latency.
module tb_fpu_sequencer;
    import fpu_pkg::*;

    localparam int TAG_W = 5;
    localparam int TO    = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = '0;
    logic             req_mode = 1'b0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;
    logic [31:0]      fpu_a, fpu_b;
    logic             fpu_go;
    logic [3:0]       fpu_control;
    logic             fpu_mode;
    logic [31:0]      fpu_c = '0;
    logic             fpu_valid = 1'b0;
    logic             busy;
    fpu_state_e       dbg_state;

    fpu_sequencer #(.TAG_W(TAG_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_mode(req_mode), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_err(resp_err),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_go(fpu_go), .fpu_control(fpu_control),
        .fpu_mode(fpu_mode), .fpu_c(fpu_c), .fpu_valid(fpu_valid),
        .busy(busy), .dbg_state(dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // expected response: {cycle[69:38], err[37], tag[36:32], data[31:0]}
    logic [69:0] exp_q[$];
    logic [69:0] mon_e;
    logic        held = 1'b0;

    // A response is "held" if it was valid and not taken at the previous edge.
    always @(posedge clk) held <= rstn && resp_valid && !resp_ready;

    // Monitor: compare each newly presented response against the queue head.
    always @(negedge clk) begin
        if (rstn && resp_valid && !held) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(resp_tag), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_data",  64'(resp_data), 64'(mon_e[31:0]));
                check("resp_tag",   64'(resp_tag),  64'(mon_e[36:32]));
                check("resp_err",   64'(resp_err),  64'(mon_e[37]));
                check("resp_cycle", 64'(cyc),       64'(mon_e[69:38]));
            end
        end
    end

    // ---------------- FPU model ----------------
    // per-op config pushed at accept: {latency[39:32] (255 = never), result[31:0]}
    logic [39:0] cfg_q[$];
    logic [39:0] m_cfg;
    int          m_lat = 0;
    int          m_cnt = 0;
    logic        m_active = 1'b0;
    logic        force_valid = 1'b0;
    int          go_cnt = 0;

    always @(negedge clk) begin
        fpu_valid = force_valid;
        if (fpu_go === 1'b1) begin
            go_cnt++;
            if (cfg_q.size() > 0) begin
                m_cfg = cfg_q.pop_front();
                m_lat = int'(m_cfg[39:32]);
                fpu_c = m_cfg[31:0];
            end else begin
                m_lat = 255;
            end
            m_cnt = 0;
            if (m_lat == 0) fpu_valid = 1'b1;
            else            m_active = (m_lat != 255);
        end else if (m_active) begin
            m_cnt++;
            if (m_cnt == m_lat) begin
                fpu_valid = 1'b1;
                m_active  = 1'b0;
            end
        end
    end

    logic bb_window = 1'b0;
    int   bb_idle = 0;
    always @(negedge clk) if (bb_window && dbg_state == IDLE) bb_idle++;

    // ---------------- driver tasks ----------------
    // Call at a negedge; returns #1 after the accepting edge (ISSUE/RESP cycle).
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic mode, input int lat,
                        input logic [31:0] res, input int resp_off,
                        input logic [31:0] exp_data, input logic exp_err);
        int n = 0;
        req_valid = 1'b1;
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_mode = mode;
        #1;
        while (!req_ready && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        if (op <= 4'd9) cfg_q.push_back({8'(lat), res});
        exp_q.push_back({32'(cyc + resp_off), exp_err, tag, exp_data});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || dbg_state != IDLE) && n < 500) begin
            @(negedge clk); n++;
        end
        if (n >= 500) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    int g0;
    int n;
    logic [37:0] snap;

    initial begin
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_resp",      64'({resp_valid, resp_err, resp_tag, resp_data}), 64'd0);
        check("reset_fpu_ops",   64'({fpu_a, fpu_b}), 64'd0);
        check("reset_fpu_ctl",   64'({fpu_go, fpu_control, fpu_mode, busy}), 64'd0);
        check("reset_state",     64'(dbg_state), 64'(IDLE));
        rstn = 1'b1;

        // fadd 1.0 + 2.0, FPU answers 3 cycles after go
        @(negedge clk);
        g0 = go_cnt;
        send(4'd0, 32'h3F800000, 32'h40000000, 5'd3, 1'b0, 3, 32'h40400000, 5, 32'h40400000, 1'b0);
        check("fadd_go",       64'(fpu_go), 64'd1);
        check("fadd_operands", 64'({fpu_a, fpu_b}), {32'h3F800000, 32'h40000000});
        @(negedge clk); @(negedge clk);
        check("fadd_hold_ops", 64'({fpu_a, fpu_b}), {32'h3F800000, 32'h40000000});
        check("fadd_hold_ctl", 64'({fpu_control, busy}), {4'd0, 1'b1});
        drain();
        check("fadd_go_pulses", 64'(go_cnt - g0), 64'd1);

        // ftoi with mode=1, 1-cycle unit
        @(negedge clk);
        send(4'd5, 32'h40E00000, 32'h0, 5'd4, 1'b1, 1, 32'h7, 3, 32'h7, 1'b0);
        check("ftoi_ctl_mode", 64'({fpu_control, fpu_mode}), {4'd5, 1'b1});
        drain();

        // illegal opcode 0xC: straight to RESP, no go
        @(negedge clk);
        g0 = go_cnt;
        send(4'hC, 32'h1234, 32'h5678, 5'd7, 1'b0, 0, 32'h0, 1, 32'h0, 1'b1);
        check("illegal_state", 64'({dbg_state, fpu_go}), {RESP, 1'b0});
        drain();
        check("illegal_no_go", 64'(go_cnt - g0), 64'd0);

        // opcode boundaries: 9 legal (zero latency), 10 illegal
        @(negedge clk);
        send(4'd9, 32'd10, 32'h0, 5'd9, 1'b0, 0, 32'h41200000, 2, 32'h41200000, 1'b0);
        drain();
        @(negedge clk);
        g0 = go_cnt;
        send(4'd10, 32'hDEAD, 32'hBEEF, 5'd10, 1'b0, 0, 32'h0, 1, 32'h0, 1'b1);
        drain();
        check("op10_no_go", 64'(go_cnt - g0), 64'd0);

        // timeout: FPU never answers
        @(negedge clk);
        send(4'd2, 32'h40000000, 32'h40000000, 5'd12, 1'b0, 255, 32'h0, 1 + TO, 32'h0, 1'b1);
        drain();
        // late valid while idle must be ignored
        @(negedge clk);
        force_valid = 1'b1;
        @(negedge clk);
        check("late_valid_idle", 64'({resp_valid, busy}), 64'd0);
        force_valid = 1'b0;
        @(negedge clk);
        check("late_valid_idle2", 64'({resp_valid, busy}), 64'd0);

        // valid coincides with timeout: result wins
        @(negedge clk);
        send(4'd3, 32'h3F800000, 32'h40000000, 5'd13, 1'b0, TO - 1, 32'h3F000000, 2 + TO - 1,
             32'h3F000000, 1'b0);
        drain();

        // backpressure: response held 5 cycles with the next request waiting
        @(negedge clk);
        resp_ready = 1'b0;
        send(4'd1, 32'h40400000, 32'h3F800000, 5'd14, 1'b0, 1, 32'h40000000, 3, 32'h40000000, 1'b0);
        req_valid = 1'b1; req_op = 4'd7; req_a = 32'd1; req_b = 32'd2; req_tag = 5'd15; req_mode = 1'b0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            @(negedge clk); n++;
        end
        check("bp_resp_seen", 64'(resp_valid), 64'd1);
        snap = {resp_err, resp_tag, resp_data};
        g0 = go_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_stable", 64'({resp_err, resp_tag, resp_data}), 64'(snap));
            check("bp_ready_go", 64'({resp_valid, req_ready, fpu_go}), {1'b1, 1'b0, 1'b0});
        end
        check("bp_no_go", 64'(go_cnt - g0), 64'd0);
        resp_ready = 1'b1;
        send(4'd7, 32'd1, 32'd2, 5'd15, 1'b0, 0, 32'd1, 2, 32'd1, 1'b0);
        check("bp_next_issue", 64'({dbg_state, fpu_go}), {ISSUE, 1'b1});
        drain();

        // reset during WAIT discards the op
        @(negedge clk);
        send(4'd0, 32'h1, 32'h2, 5'd20, 1'b0, 5, 32'hCAFE, 7, 32'hCAFE, 1'b0);
        @(negedge clk); @(negedge clk);
        check("rst_in_wait", 64'(dbg_state), 64'(WAIT));
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_resp", 64'(resp_valid), 64'd0);
        end
        check("rst_idle", 64'({dbg_state, req_ready, busy}), {IDLE, 1'b1, 1'b0});
        check("rst_cleared", 64'({fpu_a, fpu_b}), 64'd0);

        // three back-to-back zero-latency feq ops
        @(negedge clk);
        g0 = go_cnt;
        bb_idle = 0;
        send(4'd6, 32'h3F800000, 32'h3F800000, 5'd10, 1'b0, 0, 32'd1, 2, 32'd1, 1'b0);
        bb_window = 1'b1;
        @(negedge clk);
        send(4'd6, 32'h3F800000, 32'h40000000, 5'd11, 1'b0, 0, 32'd0, 2, 32'd0, 1'b0);
        @(negedge clk);
        send(4'd6, 32'h0, 32'h0, 5'd12, 1'b0, 0, 32'd1, 2, 32'd1, 1'b0);
        @(negedge clk); @(negedge clk);
        bb_window = 1'b0;
        check("bb_no_idle", 64'(bb_idle), 64'd0);
        drain();
        check("bb_go_pulses", 64'(go_cnt - g0), 64'd3);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
